// File: rtl/cache_pkg.sv
// Shared geometry, FSM state encoding and word select/merge helpers for the
// direct-mapped write-back cache.
package cache_pkg;

   localparam int ADDR_W      = 17;
   localparam int LINE_BITS   = 10;
   localparam int OFFSET_BITS = 4;
   localparam int WORD_W      = 32;
   localparam int TAG_W       = ADDR_W - LINE_BITS - OFFSET_BITS;
   localparam int LINE_W      = WORD_W << OFFSET_BITS;
   localparam int LINES       = 1 << LINE_BITS;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WRITEBACK,
      ALLOCATE,
      RESPOND
   } state_t;

   function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0]      line,
                                                  input logic [OFFSET_BITS-1:0] off);
      return line[off*WORD_W +: WORD_W];
   endfunction

   function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0]      line,
                                                  input logic [OFFSET_BITS-1:0] off,
                                                  input logic [WORD_W-1:0]      word);
      logic [LINE_W-1:0] w_res;
      w_res = line;
      w_res[off*WORD_W +: WORD_W] = word;
      return w_res;
   endfunction

endpackage

// File: rtl/cache_store.sv
// Tag, valid/dirty and line arrays: combinational read by index, registered writes.
// Flags clear in bulk on reset; tags and data are never reset.
module cache_store
   import cache_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [LINE_BITS-1:0]   i_idx,
   output logic                   o_valid,
   output logic                   o_dirty,
   output logic [TAG_W-1:0]       o_tag,
   output logic [LINE_W-1:0]      o_line,
   input  logic                   i_line_we,
   input  logic [LINE_W-1:0]      i_line_wdat,
   input  logic [TAG_W-1:0]       i_tag_wdat,
   input  logic                   i_word_we,
   input  logic [OFFSET_BITS-1:0] i_word_off,
   input  logic [WORD_W-1:0]      i_word_wdat,
   input  logic                   i_flag_we,
   input  logic                   i_valid_wdat,
   input  logic                   i_dirty_wdat
);

   logic [LINES-1:0]  r_valid;
   logic [LINES-1:0]  r_dirty;
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [LINE_W-1:0] r_data [LINES];

   assign o_valid = r_valid[i_idx];
   assign o_dirty = r_dirty[i_idx];
   assign o_tag   = r_tag[i_idx];
   assign o_line  = r_data[i_idx];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_flag_we) begin
         r_valid[i_idx] <= i_valid_wdat;
         r_dirty[i_idx] <= i_dirty_wdat;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_line_we) begin
         r_data[i_idx] <= i_line_wdat;
         r_tag[i_idx]  <= i_tag_wdat;
      end else if (i_word_we) begin
         r_data[i_idx][i_word_off*WORD_W +: WORD_W] <= i_word_wdat;
      end
   end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-back/write-allocate cache sequencer: hit done 2 cycles after accept,
// misses add one memory phase per writeback/fill; cpu_ready low (requests ignored) while busy.
module cache_controller
   import cache_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_cpu_req,
   input  logic                     i_cpu_we,
   input  logic [ADDR_W-1:0]        i_cpu_addr,
   input  logic [WORD_W-1:0]        i_cpu_wdata,
   output logic                     o_cpu_ready,
   output logic                     o_cpu_done,
   output logic [WORD_W-1:0]        o_cpu_rdata,
   output logic                     o_mem_req,
   output logic                     o_mem_we,
   output logic [ADDR_W-OFFSET_BITS-1:0] o_mem_addr,
   output logic [LINE_W-1:0]        o_mem_wdata,
   input  logic [LINE_W-1:0]        i_mem_rdata,
   input  logic                     i_mem_ack,
   output logic [CNT_W-1:0]         o_hit_cnt,
   output logic [CNT_W-1:0]         o_miss_cnt,
   output logic [CNT_W-1:0]         o_wb_cnt
);

   state_t                 r_state;
   state_t                 w_next;
   logic [ADDR_W-1:0]      r_addr;
   logic                   r_we;
   logic [WORD_W-1:0]      r_wdata;
   logic [WORD_W-1:0]      r_rdata;
   logic [CNT_W-1:0]       r_hit_cnt;
   logic [CNT_W-1:0]       r_miss_cnt;
   logic [CNT_W-1:0]       r_wb_cnt;

   logic [TAG_W-1:0]       w_tag;
   logic [LINE_BITS-1:0]   w_idx;
   logic [OFFSET_BITS-1:0] w_off;
   logic                   w_valid;
   logic                   w_dirty;
   logic [TAG_W-1:0]       w_vtag;
   logic [LINE_W-1:0]      w_line;
   logic                   w_hit;
   logic                   w_line_we;
   logic [LINE_W-1:0]      w_line_wdat;
   logic                   w_word_we;
   logic                   w_flag_we;
   logic                   w_valid_wdat;
   logic                   w_dirty_wdat;

   assign w_tag = r_addr[ADDR_W-1 -: TAG_W];
   assign w_idx = r_addr[OFFSET_BITS +: LINE_BITS];
   assign w_off = r_addr[OFFSET_BITS-1:0];
   assign w_hit = w_valid && (w_vtag == w_tag);

   cache_store u_store (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_idx        (w_idx),
      .o_valid      (w_valid),
      .o_dirty      (w_dirty),
      .o_tag        (w_vtag),
      .o_line       (w_line),
      .i_line_we    (w_line_we),
      .i_line_wdat  (w_line_wdat),
      .i_tag_wdat   (w_tag),
      .i_word_we    (w_word_we),
      .i_word_off   (w_off),
      .i_word_wdat  (r_wdata),
      .i_flag_we    (w_flag_we),
      .i_valid_wdat (w_valid_wdat),
      .i_dirty_wdat (w_dirty_wdat)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (i_cpu_req) w_next = LOOKUP;
         LOOKUP:    if (w_hit)                w_next = RESPOND;
                    else if (w_valid && w_dirty) w_next = WRITEBACK;
                    else                      w_next = ALLOCATE;
         WRITEBACK: if (i_mem_ack) w_next = ALLOCATE;
         ALLOCATE:  if (i_mem_ack) w_next = RESPOND;
         RESPOND:   w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // Memory outputs derive from state plus the untouched victim entry, so they stay
   // stable for the whole phase without extra registers.
   always_comb begin
      o_cpu_ready  = 1'b0;
      o_cpu_done   = 1'b0;
      o_mem_req    = 1'b0;
      o_mem_we     = 1'b0;
      o_mem_addr   = '0;
      o_mem_wdata  = '0;
      w_line_we    = 1'b0;
      w_line_wdat  = i_mem_rdata;
      w_word_we    = 1'b0;
      w_flag_we    = 1'b0;
      w_valid_wdat = 1'b0;
      w_dirty_wdat = 1'b0;
      case (r_state)
         IDLE:    o_cpu_ready = 1'b1;
         LOOKUP: begin
            if (w_hit && r_we) begin
               w_word_we    = 1'b1;
               w_flag_we    = 1'b1;
               w_valid_wdat = 1'b1;
               w_dirty_wdat = 1'b1;
            end
         end
         WRITEBACK: begin
            o_mem_req   = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = {w_vtag, w_idx};
            o_mem_wdata = w_line;
            if (i_mem_ack) begin
               w_flag_we    = 1'b1;
               w_valid_wdat = 1'b1;
            end
         end
         ALLOCATE: begin
            o_mem_req  = 1'b1;
            o_mem_addr = r_addr[ADDR_W-1:OFFSET_BITS];
            if (i_mem_ack) begin
               w_line_we    = 1'b1;
               w_line_wdat  = r_we ? put_word(i_mem_rdata, w_off, r_wdata) : i_mem_rdata;
               w_flag_we    = 1'b1;
               w_valid_wdat = 1'b1;
               w_dirty_wdat = r_we;
            end
         end
         RESPOND: o_cpu_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr     <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_wb_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_cpu_req) begin
                  r_addr  <= i_cpu_addr;
                  r_we    <= i_cpu_we;
                  r_wdata <= i_cpu_wdata;
               end
            end
            LOOKUP: begin
               if (w_hit) begin
                  if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
                  if (!r_we) r_rdata <= get_word(w_line, w_off);
               end else if (r_miss_cnt != '1) begin
                  r_miss_cnt <= r_miss_cnt + 1'b1;
               end
            end
            WRITEBACK: begin
               if (i_mem_ack && r_wb_cnt != '1) r_wb_cnt <= r_wb_cnt + 1'b1;
            end
            ALLOCATE: begin
               if (i_mem_ack && !r_we) r_rdata <= get_word(i_mem_rdata, w_off);
            end
            default: ;
         endcase
      end
   end

   assign o_cpu_rdata = r_rdata;
   assign o_hit_cnt   = r_hit_cnt;
   assign o_miss_cnt  = r_miss_cnt;
   assign o_wb_cnt    = r_wb_cnt;

endmodule
